// File: rtl/pin_filter_if.sv
// pin_filter_if: groups the pad-sample, filtered-pin, edge-flag and clear signals
// of pin_filter. The slave modport is the filter itself. The master modport is the
// side that supplies raw pads and the clear strobe and consumes the results.
interface pin_filter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pin_raw;
  logic [WIDTH-1:0] pin_in;
  logic [WIDTH-1:0] rise_pend;
  logic [WIDTH-1:0] fall_pend;
  logic             clr_stb;
  logic [WIDTH-1:0] clr_mask;
  logic             evt;

  modport master (
    output pin_raw,
    output clr_stb,
    output clr_mask,
    input  pin_in,
    input  rise_pend,
    input  fall_pend,
    input  evt
  );

  modport slave (
    input  pin_raw,
    input  clr_stb,
    input  clr_mask,
    output pin_in,
    output rise_pend,
    output fall_pend,
    output evt
  );
endinterface

// File: rtl/pin_filter.sv
// pin_filter: input conditioner for the I/O pins.
// Raw pad values pass through a SYNC_STAGES-deep synchronizer. A per-pin glitch
// filter then requires FILT_LEN consecutive differing samples before the filtered
// value pin_in follows. Edges of pin_in set sticky rise/fall flags. A masked strobe
// clears these flags, and a set on the same edge as a clear wins.
// Build option: define P1V_PIN_FILTER_EN to build the glitch filter. Without it,
// pin_in is a registered copy of the synchronizer output and FILT_LEN is unused.
// Reset (inp_resn) is asynchronous and active low. All state clears to 0.
module pin_filter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input logic         clk_cog,
  input logic         inp_resn,
  pin_filter_if.slave bus
);

  // Reject configurations that cannot work.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pin_filter: SYNC_STAGES must be 2 or more");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("pin_filter: FILT_LEN must be 1 or more");
  end

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] pin_in_reg;
  logic [WIDTH-1:0] pin_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic [WIDTH-1:0] clr_eff;
  logic             evt_reg;

  // Synchronizer chain. Stage 0 samples the pads, and the last stage is s.
  always_ff @(posedge clk_cog or negedge inp_resn) begin
    if (!inp_resn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= '0;
      end
    end else begin
      sync_reg[0] <= bus.pin_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign s_vec = sync_reg[SYNC_STAGES-1];

`ifdef P1V_PIN_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_filt
    logic [CNT_W-1:0] cnt_reg;
    logic             differs;
    logic             accept;

    assign differs      = (s_vec[gi] != pin_in_reg[gi]);
    assign accept       = differs && (cnt_reg == CNT_LAST);
    assign pin_next[gi] = accept ? s_vec[gi] : pin_in_reg[gi];

    // Count consecutive samples where s differs from pin_in. Any agreement, or the
    // accepted change itself, restarts the count, so it never passes CNT_LAST.
    always_ff @(posedge clk_cog or negedge inp_resn) begin
      if (!inp_resn) begin
        cnt_reg <= '0;
      end else if (!differs || accept) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end
`else
  // Without the filter, pin_in follows s one edge later.
  assign pin_next = s_vec;
`endif

  // A flag set (edge on pin_in) overrides a clear on the same bit.
  assign clr_eff   = bus.clr_stb ? bus.clr_mask : '0;
  assign rise_next = (rise_reg & ~clr_eff) | (pin_next & ~pin_in_reg);
  assign fall_next = (fall_reg & ~clr_eff) | (~pin_next & pin_in_reg);

  // Filtered pins, sticky edge flags and the event summary, all registered.
  always_ff @(posedge clk_cog or negedge inp_resn) begin
    if (!inp_resn) begin
      pin_in_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      evt_reg    <= 1'b0;
    end else begin
      pin_in_reg <= pin_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      evt_reg    <= |(rise_next | fall_next);
    end
  end

  assign bus.pin_in    = pin_in_reg;
  assign bus.rise_pend = rise_reg;
  assign bus.fall_pend = fall_reg;
  assign bus.evt       = evt_reg;

endmodule

// File: tb/tb_pin_filter.sv
// tb_pin_filter: directed and random stimulus for pin_filter. A reference model
// keeps a window of recent raw samples. A pin changes once the delayed samples
// have held the new value for the filter length. Edge flags follow the set-wins
// clear rule. Every edge compares all outputs against the model.
module tb_pin_filter;
  localparam int W    = 32;
  localparam int SS   = 2;
  localparam int FLEN = 4;
`ifdef P1V_PIN_FILTER_EN
  localparam int FL = FLEN;
`else
  localparam int FL = 1;
`endif
  localparam int LAT = SS + FL;
  localparam int HN  = SS + FL;

  logic clk_cog  = 1'b0;
  logic inp_resn = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  logic [W-1:0] hist [HN];
  logic [W-1:0] m_pin;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic         m_evt;

  pin_filter_if #(.WIDTH(W)) bus ();

  pin_filter #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .FILT_LEN(FLEN)
  ) dut (
    .clk_cog (clk_cog),
    .inp_resn(inp_resn),
    .bus     (bus)
  );

  always #5 clk_cog = ~clk_cog;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pin  = '0;
    m_rise = '0;
    m_fall = '0;
    m_evt  = 1'b0;
    for (int k = 0; k < HN; k++) hist[k] = '0;
  endtask

  // hist[0] holds the raw sample of this edge. The filter looks at samples that are
  // SS..SS+FL-1 edges old.
  task automatic model_edge(input logic [W-1:0] raw, input logic stb, input logic [W-1:0] mask);
    logic [W-1:0] all_one;
    logic [W-1:0] all_zero;
    logic [W-1:0] new_pin;
    logic [W-1:0] clr;
    for (int k = HN - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0]  = raw;
    all_one  = '1;
    all_zero = '1;
    for (int k = SS; k < HN; k++) begin
      all_one  &= hist[k];
      all_zero &= ~hist[k];
    end
    new_pin = (m_pin | all_one) & ~all_zero;
    clr     = stb ? mask : '0;
    m_rise  = (m_rise & ~clr) | (new_pin & ~m_pin);
    m_fall  = (m_fall & ~clr) | (~new_pin & m_pin);
    m_pin   = new_pin;
    m_evt   = |(m_rise | m_fall);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pin_in"}, bus.pin_in, m_pin);
    chk({tag, ".rise"}, bus.rise_pend, m_rise);
    chk({tag, ".fall"}, bus.fall_pend, m_fall);
    chk({tag, ".evt"}, W'(bus.evt), W'(m_evt));
  endtask

  task automatic step(input string tag);
    logic [W-1:0] raw;
    logic [W-1:0] mask;
    logic         stb;
    raw  = bus.pin_raw;
    stb  = bus.clr_stb;
    mask = bus.clr_mask;
    @(posedge clk_cog);
    #1;
    if (inp_resn) model_edge(raw, stb, mask);
    else model_reset();
    $display("%0t %s raw=%h stb=%b mask=%h pin_in=%h rise=%h fall=%h evt=%b",
             $time, tag, raw, stb, mask, bus.pin_in, bus.rise_pend, bus.fall_pend, bus.evt);
    check_all(tag);
  endtask

  task automatic settle(input string tag, input int n);
    repeat (n) step(tag);
  endtask

  task automatic pulse_clear(input string tag, input logic [W-1:0] mask);
    bus.clr_stb  = 1'b1;
    bus.clr_mask = mask;
    step(tag);
    bus.clr_stb  = 1'b0;
    bus.clr_mask = '0;
  endtask

  // Edges until pin_in[b] reaches v, bounded. A miss reports -1.
  task automatic wait_bit(input string tag, input int b, input logic v, input int exp_edges);
    int got;
    got = -1;
    for (int i = 1; i <= 40; i++) begin
      step(tag);
      if (bus.pin_in[b] === v) begin
        got = i;
        break;
      end
    end
    chk({tag, ".latency"}, W'(got), W'(exp_edges));
  endtask

  // Raw pulse of w cycles on pin 0. It passes with its width only if w >= FL.
  task automatic glitch(input string tag, input int w);
    int hi;
    hi = 0;
    bus.pin_raw[0] = 1'b1;
    repeat (w) begin
      step(tag);
      if (bus.pin_in[0] === 1'b1) hi++;
    end
    bus.pin_raw[0] = 1'b0;
    repeat (LAT + 2) begin
      step(tag);
      if (bus.pin_in[0] === 1'b1) hi++;
    end
    chk({tag, ".width"}, W'(hi), W'((w >= FL) ? w : 0));
    chk({tag, ".rise0"}, W'(bus.rise_pend[0]), W'(w >= FL));
    chk({tag, ".fall0"}, W'(bus.fall_pend[0]), W'(w >= FL));
    pulse_clear({tag, ".clr"}, '1);
  endtask

  initial begin
    bus.pin_raw  = '1;
    bus.clr_stb  = 1'b0;
    bus.clr_mask = '0;
    model_reset();

    // Reset held with all pads high. All outputs stay 0.
    settle("reset", 3);
    inp_resn = 1'b1;
    wait_bit("release", 0, 1'b1, LAT);
    chk("release.all_pins", bus.pin_in, '1);
    chk("release.rise_all", bus.rise_pend, '1);
    pulse_clear("clr_all", '1);

    // Asynchronous reset between edges, then step latency on pin 5.
    inp_resn    = 1'b0;
    bus.pin_raw = '0;
    #1;
    model_reset();
    check_all("async_rst");
    step("rst_hold");
    inp_resn = 1'b1;
    settle("idle", LAT + 2);
    bus.pin_raw[5] = 1'b1;
    wait_bit("step5", 5, 1'b1, LAT);
    chk("step5.rise", bus.rise_pend, 32'h0000_0020);
    chk("step5.fall", bus.fall_pend, '0);

    // Masked clear.
    bus.pin_raw = 32'h0000_00FF;
    settle("set_ff", LAT + 1);
    chk("mask.pre", bus.rise_pend, 32'h0000_00FF);
    pulse_clear("mask_lo", 32'h0000_000F);
    chk("mask_lo.rise", bus.rise_pend, 32'h0000_00F0);
    chk("mask_lo.evt", W'(bus.evt), W'(1));
    pulse_clear("mask_hi", 32'h0000_00F0);
    chk("mask_hi.rise", bus.rise_pend, '0);
    chk("mask_hi.evt", W'(bus.evt), W'(0));

    // Glitch rejection.
    bus.pin_raw = '0;
    settle("drop", LAT + 2);
    pulse_clear("clr_drop", '1);
    glitch("glitch3", 3);
    glitch("glitch4", 4);

    // Set/clear collision on pin 3.
    bus.pin_raw[3] = 1'b1;
    settle("coll", LAT - 1);
    bus.clr_stb  = 1'b1;
    bus.clr_mask = 32'h0000_0008;
    step("coll.clr");
    bus.clr_stb  = 1'b0;
    bus.clr_mask = '0;
    chk("coll.pin3", W'(bus.pin_in[3]), W'(1));
    chk("coll.rise3", W'(bus.rise_pend[3]), W'(1));

    // Reset in the middle of a count on pin 7.
    bus.pin_raw = '0;
    settle("quiet", LAT + 2);
    pulse_clear("clr_quiet", '1);
    bus.pin_raw[7] = 1'b1;
    settle("midcnt", 4);
    #2;
    inp_resn = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    step("midrst.hold");
    inp_resn = 1'b1;
    wait_bit("midrst", 7, 1'b1, LAT);

    // Random toggles with random masked clears, plus one reset along the way.
    for (int i = 0; i < 400; i++) begin
      bus.pin_raw = bus.pin_raw ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.clr_stb  = 1'b1;
        bus.clr_mask = $urandom;
      end else begin
        bus.clr_stb  = 1'b0;
        bus.clr_mask = '0;
      end
      inp_resn = (i != 200);
      step("rand");
    end
    inp_resn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
